// File: rtl/ams_pwm_dac_pkg.sv
// Shared constants and helpers for the AMS slow-DAC PWM path.
package ams_pkg;
  localparam int AMS_DAC_W = 24;
  localparam int BASE_HI   = 23;
  localparam int BASE_LO   = 16;
  localparam int PAT_W     = 16;
  localparam int CCRE_DEF  = 156;
  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 8;
  localparam int IDX_W     = 4;
  localparam int THR_W     = CNT_W + 1;

  // One analog-output word as seen from the register bank.
  typedef struct packed {
    logic [BASE_HI-BASE_LO:0] base;
    logic [PAT_W-1:0]         pat;
  } dac_word_t;

  // High-time threshold for dither slot idx: base plus one LSB if the
  // pattern bit is set. 255+1 still fits in THR_W bits.
  function automatic logic [THR_W-1:0] dac_thr(dac_word_t w, logic [IDX_W-1:0] idx);
    return {1'b0, w.base} + THR_W'(w.pat[idx]);
  endfunction
endpackage

// File: rtl/ams_pwm_dac_if.sv
// Config words in, PWM pins and superframe strobe out.
interface ams_pwm_dac_if;
  import ams_pkg::*;
  logic [AMS_DAC_W-1:0] cfg_a_i;
  logic [AMS_DAC_W-1:0] cfg_b_i;
  logic [AMS_DAC_W-1:0] cfg_c_i;
  logic [AMS_DAC_W-1:0] cfg_d_i;
  logic [NUM_CH-1:0]    pwm_o;
  logic                 sf_o;

  modport master (output cfg_a_i, cfg_b_i, cfg_c_i, cfg_d_i, input pwm_o, sf_o);
  modport slave  (input cfg_a_i, cfg_b_i, cfg_c_i, cfg_d_i, output pwm_o, sf_o);
endinterface

// File: rtl/ams_pwm_channel.sv
// One PWM lane: shadowed config word, dithered threshold, registered compare.
module ams_pwm_channel
  import ams_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CNT_W-1:0]     cnt,
  input  logic [IDX_W-1:0]     idx,
  input  logic                 ld,
  input  logic [AMS_DAC_W-1:0] cfg,
  output logic                 pwm
);
  dac_word_t        shd;
  logic [THR_W-1:0] thr;

  // Shadow only updates on the superframe boundary so a frame never mixes words.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)   shd <= '0;
    else if (ld) shd <= dac_word_t'(cfg);
  end

  // Threshold for the current dither slot.
  always_comb begin
    thr = dac_thr(shd, idx);
  end

  // Registered compare; thr above the period length saturates high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pwm <= 1'b0;
    else       pwm <= ({1'b0, cnt} < thr);
  end
endmodule

// File: rtl/ams_pwm_dac.sv
// Four phase-aligned sigma-delta-dithered PWM outputs sharing one period
// counter and one dither index.
module ams_pwm_dac
  import ams_pkg::*;
#(
  parameter int CCRE = CCRE_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ams_pwm_dac_if.slave bus
);
  logic [CNT_W-1:0]                   cnt;
  logic [IDX_W-1:0]                   idx;
  logic                               ld;
  logic                               sf_q;
  logic [NUM_CH-1:0]                  pwm;
  logic [NUM_CH-1:0][AMS_DAC_W-1:0]   cfg;

  assign cfg = {bus.cfg_d_i, bus.cfg_c_i, bus.cfg_b_i, bus.cfg_a_i};

  // Boundary: last cycle of the last period in the superframe.
  always_comb begin
    ld = (cnt == CNT_W'(CCRE)) && (idx == {IDX_W{1'b1}});
  end

  // Period counter 0..CCRE; dither index advances on every wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_W'(CCRE)) begin
      cnt <= '0;
      idx <= idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Superframe strobe registered alongside the shadow reload.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sf_q <= 1'b0;
    else       sf_q <= ld;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ams_pwm_channel u_ch (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .cnt   (cnt),
      .idx   (idx),
      .ld    (ld),
      .cfg   (cfg[g]),
      .pwm   (pwm[g])
    );
  end

  assign bus.pwm_o = pwm;
  assign bus.sf_o  = sf_q;
endmodule

// File: tb/tb_ams_pwm_dac.sv
// Directed bench for ams_pwm_dac with CCRE=156: counts high cycles per
// period per channel over whole superframes.
`timescale 1ns/100ps
module tb_ams_pwm_dac;
  localparam int P  = 157;
  localparam int SF = 16 * P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #2 clk = ~clk;

  ams_pwm_dac_if bus();
  ams_pwm_dac #(.CCRE(156)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int hi[4][16];

  // Run one full superframe starting just after an sf_o sample; applies new
  // cfg words at sample chg. Fills hi[][] and checks sf_o placement.
  task automatic run_sf(input int chg, input logic [23:0] a, b, c, d);
    int sf_bad = 0;
    for (int ch = 0; ch < 4; ch++)
      for (int i = 0; i < 16; i++) hi[ch][i] = 0;
    for (int k = 1; k <= SF; k++) begin
      @(negedge clk);
      for (int ch = 0; ch < 4; ch++)
        if (bus.pwm_o[ch] === 1'b1) hi[ch][(k-1)/P]++;
      if (bus.sf_o !== (k == SF)) sf_bad++;
      if (k == chg) begin
        bus.cfg_a_i = a; bus.cfg_b_i = b; bus.cfg_c_i = c; bus.cfg_d_i = d;
      end
    end
    n_cmp++;
    if (sf_bad != 0) begin
      n_bad++;
      $display("FAIL sf_period: %0d misplaced sf_o samples, required 0", sf_bad);
    end
  endtask

  task automatic test_reset();
    int pwm_bad = 0;
    int sf_bad  = 0;
    bus.cfg_a_i = 24'h4E_0000; bus.cfg_b_i = 24'h4E_FFFF;
    bus.cfg_c_i = 24'h0F_0001; bus.cfg_d_i = 24'h9C_FFFF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.pwm_o !== 4'h0 || bus.sf_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: pwm=%h sf=%b, required 0/0", bus.pwm_o, bus.sf_o);
    end
    rst = 1'b0;
    for (int k = 1; k <= SF; k++) begin
      @(negedge clk);
      if (bus.pwm_o !== 4'h0) pwm_bad++;
      if (bus.sf_o !== (k == SF)) sf_bad++;
    end
    n_cmp++;
    if (pwm_bad != 0) begin
      n_bad++;
      $display("FAIL reset_frame_low: %0d non-zero pwm samples, required 0", pwm_bad);
    end
    n_cmp++;
    if (sf_bad != 0) begin
      n_bad++;
      $display("FAIL reset_sf_at_2512: %0d misplaced sf_o samples, required 0", sf_bad);
    end
  endtask

  // Superframe 1: plain duty on A/B, dither on C, saturation on D.
  task automatic test_plain_dither_sat();
    int tot = 0;
    run_sf(1, 24'h4E_0000, 24'h4E_FFFF, 24'h00_0000, 24'hFF_0000);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (hi[0][i] !== 78) begin
        n_bad++; $display("FAIL plain_a idx%0d: high=%0d, required 78", i, hi[0][i]);
      end
      n_cmp++;
      if (hi[1][i] !== 79) begin
        n_bad++; $display("FAIL plain_b idx%0d: high=%0d, required 79", i, hi[1][i]);
      end
      n_cmp++;
      if (hi[2][i] !== ((i == 0) ? 16 : 15)) begin
        n_bad++; $display("FAIL dither_c idx%0d: high=%0d, required %0d", i, hi[2][i], (i == 0) ? 16 : 15);
      end
      n_cmp++;
      if (hi[3][i] !== P) begin
        n_bad++; $display("FAIL sat_d_9c idx%0d: high=%0d, required 157", i, hi[3][i]);
      end
      tot += hi[2][i];
    end
    n_cmp++;
    if (tot !== 241) begin
      n_bad++; $display("FAIL dither_total: high=%0d, required 241", tot);
    end
  endtask

  // Superframe 2: C at zero (constant low), D at FF (constant high).
  task automatic test_saturation();
    run_sf(1, 24'h0F_0000, 24'h4E_FFFF, 24'hFF_0000, 24'hFF_0000);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (hi[2][i] !== 0) begin
        n_bad++; $display("FAIL zero_c idx%0d: high=%0d, required 0", i, hi[2][i]);
      end
      n_cmp++;
      if (hi[3][i] !== P) begin
        n_bad++; $display("FAIL sat_d_ff idx%0d: high=%0d, required 157", i, hi[3][i]);
      end
    end
  endtask

  // Superframe 3: A at 0x0F, changed to 0x75 at idx 7; superframe 4 shows 117.
  task automatic test_midframe();
    run_sf(7*P + 1, 24'h75_0000, 24'h4E_FFFF, 24'hFF_0000, 24'hFF_0000);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (hi[0][i] !== 15) begin
        n_bad++; $display("FAIL mid_old_a idx%0d: high=%0d, required 15", i, hi[0][i]);
      end
    end
    run_sf(0, 24'h0, 24'h0, 24'h0, 24'h0);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (hi[0][i] !== 117) begin
        n_bad++; $display("FAIL mid_new_a idx%0d: high=%0d, required 117", i, hi[0][i]);
      end
      n_cmp++;
      if (hi[2][i] !== P) begin
        n_bad++; $display("FAIL sat_c_ff idx%0d: high=%0d, required 157", i, hi[2][i]);
      end
    end
  endtask

  // Reset asserted between clock edges while all outputs are high.
  task automatic test_async_reset();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.pwm_o !== 4'hF) begin
      n_bad++; $display("FAIL pre_reset_all_high: pwm=%h, required f", bus.pwm_o);
    end
    #1 rst = 1'b1;
    #0.5;
    n_cmp++;
    if (bus.pwm_o !== 4'h0 || bus.sf_o !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: pwm=%h sf=%b, required 0/0", bus.pwm_o, bus.sf_o);
    end
  endtask

  initial begin
    bus.cfg_a_i = '0; bus.cfg_b_i = '0; bus.cfg_c_i = '0; bus.cfg_d_i = '0;
    test_reset();
    test_plain_dither_sat();
    test_saturation();
    test_midframe();
    test_async_reset();
    test_reset();
    test_plain_dither_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
